// File: rtl/cart_loader.sv
// Streams ioctl download bytes into the BIOS or cart RAM through a small write FIFO,
// stripping and decoding the 7800 "ATARI" header on cart loads.
module cart_loader #(
    parameter int         ADDR_W     = 18,
    parameter int         HDR_LEN    = 128,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] BIOS_INDEX = 8'd0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic              ioctl_wait,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic              cart_is_7800,
    output logic [15:0]       cart_flags,
    output logic [7:0]        joy0_type,
    output logic [7:0]        joy1_type,
    output logic [7:0]        cart_region,
    output logic [7:0]        cart_save,
    output logic [31:0]       cart_size,
    output logic              load_done,
    output logic              busy,
    output logic              err_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + ADDR_W + 8;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_HIGH = (PTR_W+1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;

    logic        dl_q;
    logic        sel_cart;
    logic        sig_ok;
    logic        any_wr;
    logic [24:0] last_addr;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;

    logic              dl_rise;
    logic              dl_fall;
    logic              wr_ev;
    logic              in_hdr;
    logic              push_req;
    logic              full;
    logic              push;
    logic              drop;
    logic              accept;
    logic              pop;
    logic              hi_water;
    logic [ADDR_W-1:0] push_addr;
    logic [ENT_W-1:0]  head;
    logic [7:0]        sig_ch;
    logic              sig_pos;
    logic              sig_match;
    logic [31:0]       size_all;
    logic [31:0]       size_net;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign wr_ev    = (state == S_LOAD) & ioctl_wr;
    assign in_hdr   = sel_cart & cart_is_7800 & (ioctl_addr < 25'(HDR_LEN));
    assign push_req = wr_ev & ~in_hdr;
    assign full     = (count == CNT_FULL);
    assign push     = push_req & ~full;
    assign drop     = push_req & full;
    assign accept   = wr_ev & ~drop;

    assign mem_we = (count != '0);
    assign pop    = mem_we & mem_ack;

    assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign hi_water  = (count_nxt >= CNT_HIGH);

    // Once the signature is known, payload lands at file offset minus header.
    assign push_addr = (sel_cart & cart_is_7800)
                     ? ADDR_W'(ioctl_addr - 25'(HDR_LEN))
                     : ioctl_addr[ADDR_W-1:0];

    assign head = fifo_mem[rd_ptr];
    assign {mem_sel, mem_addr, mem_data} = mem_we ? head : '0;

    always_comb begin
        sig_ch  = 8'h00;
        sig_pos = 1'b1;
        case (ioctl_addr)
            25'd1:   sig_ch = 8'h41;
            25'd2:   sig_ch = 8'h54;
            25'd3:   sig_ch = 8'h41;
            25'd4:   sig_ch = 8'h52;
            25'd5:   sig_ch = 8'h49;
            default: sig_pos = 1'b0;
        endcase
    end

    assign sig_match = sig_pos & (ioctl_dout == sig_ch);

    // Byte count excluding the header, clamped at zero.
    assign size_all = 32'(last_addr) + 32'd1;

    always_comb begin
        size_net = size_all;
        if (!any_wr) begin
            size_net = '0;
        end else if (cart_is_7800) begin
            if (size_all < 32'(HDR_LEN)) begin
                size_net = '0;
            end else begin
                size_net = size_all - 32'(HDR_LEN);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {sel_cart, push_addr, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            dl_q         <= 1'b0;
            sel_cart     <= 1'b0;
            sig_ok       <= 1'b0;
            any_wr       <= 1'b0;
            last_addr    <= '0;
            ioctl_wait   <= 1'b0;
            cart_is_7800 <= 1'b0;
            cart_flags   <= '0;
            joy0_type    <= '0;
            joy1_type    <= '0;
            cart_region  <= '0;
            cart_save    <= '0;
            cart_size    <= '0;
            load_done    <= 1'b0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            load_done  <= 1'b0;
            ioctl_wait <= hi_water;

            if (drop) begin
                err_overflow <= 1'b1;
            end

            if (accept & sel_cart) begin
                last_addr <= ioctl_addr;
                any_wr    <= 1'b1;
                case (ioctl_addr)
                    25'd1:   sig_ok <= sig_match;
                    25'd2,
                    25'd3,
                    25'd4:   sig_ok <= sig_ok & sig_match;
                    25'd5:   cart_is_7800 <= sig_ok & sig_match;
                    25'd53:  cart_flags[15:8] <= ioctl_dout;
                    25'd54:  cart_flags[7:0] <= ioctl_dout;
                    25'd55:  joy0_type <= ioctl_dout;
                    25'd56:  joy1_type <= ioctl_dout;
                    25'd57:  cart_region <= ioctl_dout;
                    25'd58:  cart_save <= ioctl_dout;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (dl_rise) begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        sel_cart <= (ioctl_index != BIOS_INDEX);
                        if (ioctl_index != BIOS_INDEX) begin
                            sig_ok       <= 1'b0;
                            any_wr       <= 1'b0;
                            last_addr    <= '0;
                            cart_is_7800 <= 1'b0;
                            cart_flags   <= '0;
                            joy0_type    <= '0;
                            joy1_type    <= '0;
                            cart_region  <= '0;
                            cart_save    <= '0;
                            cart_size    <= '0;
                            err_overflow <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (dl_fall) begin
                        state      <= S_DRAIN;
                        ioctl_wait <= 1'b1;
                        if (sel_cart) begin
                            cart_size <= size_net;
                        end
                    end
                end
                S_DRAIN: begin
                    ioctl_wait <= 1'b1;
                    // Leave as the last entry pops so load_done trails it by one cycle.
                    if (count_nxt == '0) begin
                        state     <= S_DONE;
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: random file contents driven through the ioctl port,
// memory writes compared against a file-level reference model.
module tb_cart_loader;

    localparam int ADDR_W = 18;
    localparam int HDR    = 128;
    localparam int DEPTH  = 4;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic              ioctl_download = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic              ioctl_wr = 1'b0;
    logic              ioctl_wait;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_ack = 1'b1;
    logic              cart_is_7800;
    logic [15:0]       cart_flags;
    logic [7:0]        joy0_type;
    logic [7:0]        joy1_type;
    logic [7:0]        cart_region;
    logic [7:0]        cart_save;
    logic [31:0]       cart_size;
    logic              load_done;
    logic              busy;
    logic              err_overflow;

    cart_loader #(
        .ADDR_W(ADDR_W),
        .HDR_LEN(HDR),
        .FIFO_DEPTH(DEPTH),
        .BIOS_INDEX(8'd0)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait),
        .mem_we(mem_we),
        .mem_sel(mem_sel),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_ack(mem_ack),
        .cart_is_7800(cart_is_7800),
        .cart_flags(cart_flags),
        .joy0_type(joy0_type),
        .joy1_type(joy1_type),
        .cart_region(cart_region),
        .cart_save(cart_save),
        .cart_size(cart_size),
        .load_done(load_done),
        .busy(busy),
        .err_overflow(err_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    logic [7:0]  file_mem [0:40959];
    int          file_len;
    logic [26:0] got[$];
    logic [26:0] exp_q[$];
    int          cyc = 0;
    int          done_cycles = 0;
    int          done_cyc = 0;
    int          last_pop_cyc = 0;
    int          wait_hits = 0;

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (mem_we && mem_ack) begin
            got.push_back({mem_sel, mem_addr, mem_data});
            last_pop_cyc = cyc;
        end
        if (load_done) begin
            done_cycles++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic make_raw(input int n);
        file_len = n;
        for (int i = 0; i < n; i++) file_mem[i] = 8'($urandom);
        if (file_mem[1] == 8'h41) file_mem[1] = 8'h42;
    endtask

    task automatic make_7800(input int payload, input logic [15:0] flags,
                             input logic [7:0] region);
        file_len = HDR + payload;
        for (int i = 0; i < file_len; i++) file_mem[i] = 8'($urandom);
        file_mem[1]  = 8'h41;
        file_mem[2]  = 8'h54;
        file_mem[3]  = 8'h41;
        file_mem[4]  = 8'h52;
        file_mem[5]  = 8'h49;
        file_mem[53] = flags[15:8];
        file_mem[54] = flags[7:0];
        file_mem[57] = region;
    endtask

    // Reference: what the RAM should see for the whole file, and the size.
    task automatic build_model(input bit cart, output bit is78, output int size);
        int a;
        exp_q.delete();
        is78 = cart && file_mem[1] == 8'h41 && file_mem[2] == 8'h54 &&
               file_mem[3] == 8'h41 && file_mem[4] == 8'h52 && file_mem[5] == 8'h49;
        for (int i = 0; i < file_len; i++) begin
            if (!(is78 && i > 5 && i < HDR)) begin
                a = (is78 && i > 5) ? i - HDR : i;
                exp_q.push_back({cart, 18'(a), file_mem[i]});
            end
        end
        if (file_len == 0) size = 0;
        else if (is78) size = (file_len > HDR) ? file_len - HDR : 0;
        else size = file_len;
    endtask

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (got[i]) if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic start_dl(input logic [7:0] idx);
        got.delete();
        done_cycles = 0;
        wait_hits = 0;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_byte(input int a, input bit honour);
        int g = 0;
        while (honour && ioctl_wait === 1'b1 && g < 1000) begin
            wait_hits++;
            tick();
            g++;
        end
        checks++;
        if (g >= 1000) begin
            errors++;
            $display("FAIL wait_timeout: ioctl_wait=%b stuck, required release", ioctl_wait);
        end
        ioctl_addr = 25'(a);
        ioctl_dout = file_mem[a];
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_cycles == 0 && g < 5000) begin
            tick();
            g++;
        end
        checks++;
        if (done_cycles == 0) begin
            errors++;
            $display("FAIL done_timeout: load_done never seen, required 1 pulse");
        end
        tick();
        tick();
    endtask

    task automatic send_file(input logic [7:0] idx, input bit gaps);
        start_dl(idx);
        for (int i = 0; i < file_len; i++) begin
            send_byte(i, 1'b1);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        end_dl();
        wait_done();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ioctl_wait, mem_we, mem_sel, mem_addr, mem_data, cart_is_7800, cart_flags,
             joy0_type, joy1_type, cart_region, cart_save, cart_size, load_done,
             busy, err_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b busy=%b wait=%b size=%0d, required all 0",
                     mem_we, busy, ioctl_wait, cart_size);
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        start_dl(8'd0);
        ioctl_addr = 25'd7;
        ioctl_dout = 8'h5A;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        checks++;
        if ({mem_we, mem_sel, mem_addr, mem_data} !== {1'b1, 1'b0, 18'd7, 8'h5A}) begin
            errors++;
            $display("FAIL latency: we=%b sel=%b addr=%0d data=%h, required 1 0 7 5a",
                     mem_we, mem_sel, mem_addr, mem_data);
        end
        end_dl();
        wait_done();
    endtask

    task automatic test_bios();
        bit is78;
        int sz;
        int d;
        make_raw(4096);
        build_model(1'b0, is78, sz);
        send_file(8'd0, 1'b0);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bios_stream: diff_at=%0d got_n=%0d, required %0d in order",
                     d, got.size(), exp_q.size());
        end
        checks++;
        if (cart_size !== 32'd0) begin
            errors++;
            $display("FAIL bios_size: got %0d, required 0", cart_size);
        end
        checks++;
        if (done_cycles != 1) begin
            errors++;
            $display("FAIL bios_done: got %0d cycles, required 1", done_cycles);
        end
        checks++;
        if (wait_hits != 0) begin
            errors++;
            $display("FAIL bios_wait: got %0d wait cycles, required 0", wait_hits);
        end
    endtask

    task automatic check_7800(input string nm, input int payload,
                              input logic [15:0] flags, input logic [7:0] region);
        bit is78;
        int sz;
        int d;
        build_model(1'b1, is78, sz);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL %s_stream: diff_at=%0d got_n=%0d, required %0d",
                     nm, d, got.size(), exp_q.size());
        end
        checks++;
        if ({cart_is_7800, cart_flags, cart_region} !== {1'b1, flags, region}) begin
            errors++;
            $display("FAIL %s_hdr: is7800=%b flags=%h region=%h, required 1 %h %h",
                     nm, cart_is_7800, cart_flags, cart_region, flags, region);
        end
        checks++;
        if ({joy0_type, joy1_type, cart_save} !== {file_mem[55], file_mem[56], file_mem[58]}) begin
            errors++;
            $display("FAIL %s_joy: got %h %h %h, required %h %h %h", nm, joy0_type,
                     joy1_type, cart_save, file_mem[55], file_mem[56], file_mem[58]);
        end
        checks++;
        if (cart_size !== 32'(payload)) begin
            errors++;
            $display("FAIL %s_size: got %0d, required %0d", nm, cart_size, payload);
        end
        checks++;
        if (got.size() < 7 || got[6] !== {1'b1, 18'd0, file_mem[HDR]}) begin
            errors++;
            $display("FAIL %s_first_payload: n=%0d, required byte %0d at addr 0",
                     nm, got.size(), HDR);
        end
        checks++;
        if (done_cycles != 1) begin
            errors++;
            $display("FAIL %s_done: got %0d, required 1", nm, done_cycles);
        end
    endtask

    task automatic test_cart7800();
        make_7800(32768, 16'h1234, 8'h01);
        send_file(8'd1, 1'b0);
        check_7800("c7800", 32768, 16'h1234, 8'h01);
    endtask

    task automatic test_raw2600();
        bit is78;
        int sz;
        int d;
        make_raw(4096);
        build_model(1'b1, is78, sz);
        send_file(8'd3, 1'b1);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL raw_stream: diff_at=%0d got_n=%0d, required %0d",
                     d, got.size(), exp_q.size());
        end
        checks++;
        if ({cart_is_7800, cart_size} !== {1'b0, 32'd4096}) begin
            errors++;
            $display("FAIL raw_hdr: is7800=%b size=%0d, required 0 4096",
                     cart_is_7800, cart_size);
        end
        checks++;
        if (cart_flags !== {file_mem[53], file_mem[54]}) begin
            errors++;
            $display("FAIL raw_flags: got %h, required %h", cart_flags,
                     {file_mem[53], file_mem[54]});
        end
    endtask

    task automatic test_back_to_back_backpressure();
        bit is78;
        int sz;
        int d;
        make_raw(64);
        build_model(1'b1, is78, sz);
        fork
            send_file(8'd2, 1'b0);
            begin
                repeat (5) tick();
                mem_ack = 1'b0;
                repeat (10) tick();
                checks++;
                if ({ioctl_wait, mem_we, err_overflow} !== 3'b110) begin
                    errors++;
                    $display("FAIL bp_hold: wait=%b we=%b ovf=%b, required 1 1 0",
                             ioctl_wait, mem_we, err_overflow);
                end
                mem_ack = 1'b1;
            end
        join
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bp_stream: diff_at=%0d got_n=%0d, required %0d",
                     d, got.size(), exp_q.size());
        end
        checks++;
        if (err_overflow !== 1'b0 || wait_hits == 0) begin
            errors++;
            $display("FAIL bp_flow: ovf=%b wait_hits=%0d, required 0 and >0",
                     err_overflow, wait_hits);
        end
        checks++;
        if (cart_size !== 32'd64) begin
            errors++;
            $display("FAIL bp_size: got %0d, required 64", cart_size);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] prev_flags;
        prev_flags = cart_flags;
        make_raw(6);
        mem_ack = 1'b0;
        start_dl(8'd0);
        for (int i = 0; i < 6; i++) send_byte(i, 1'b0);
        end_dl();
        repeat (3) tick();
        checks++;
        if (err_overflow !== 1'b1 || got.size() != 0) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b pops=%0d, required 1 0", err_overflow, got.size());
        end
        mem_ack = 1'b1;
        wait_done();
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL ovf_count: got %0d entries, required 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== {1'b0, 18'(i), file_mem[i]}) begin
                    errors++;
                    $display("FAIL ovf_entry%0d: got %h, required %h", i, got[i],
                             {1'b0, 18'(i), file_mem[i]});
                end
            end
        end
        checks++;
        if (done_cyc - last_pop_cyc != 1) begin
            errors++;
            $display("FAIL done_timing: got %0d cycles after last pop, required 1",
                     done_cyc - last_pop_cyc);
        end
        checks++;
        if (cart_size !== 32'd64 || cart_flags !== prev_flags) begin
            errors++;
            $display("FAIL bios_keeps_cart: size=%0d flags=%h, required 64 %h",
                     cart_size, cart_flags, prev_flags);
        end
    endtask

    task automatic test_reset_midload();
        make_7800(4096, 16'hBEEF, 8'h02);
        start_dl(8'd1);
        for (int i = 0; i < 200; i++) send_byte(i, 1'b1);
        checks++;
        if (cart_is_7800 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_sig: got %b, required 1", cart_is_7800);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({ioctl_wait, mem_we, mem_sel, mem_addr, mem_data, cart_is_7800, cart_flags,
             joy0_type, joy1_type, cart_region, cart_save, cart_size, load_done,
             busy, err_overflow} !== '0) begin
            errors++;
            $display("FAIL midload_reset: we=%b busy=%b sig=%b flags=%h, required all 0",
                     mem_we, busy, cart_is_7800, cart_flags);
        end
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        send_file(8'd1, 1'b0);
        check_7800("reload", 4096, 16'hBEEF, 8'h02);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bios();
        test_cart7800();
        test_raw2600();
        test_back_to_back_backpressure();
        test_overflow();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cart_loader.md
# cart_loader

Streaming ROM loader between the HPS ioctl download port and the cart/BIOS dual-port RAMs. It routes each downloaded byte to the BIOS or cart region by `ioctl_index` and detects the 7800 "ATARI" header. When the header is present, the loader captures its fields and strips `HDR_LEN` bytes from the payload. Writes are buffered in a small FIFO with a memory-side ready handshake and host backpressure via `ioctl_wait`. This generalises the fixed inline header/size logic into one block parametrised in address width, header length, buffer depth and BIOS index.

## Interface
Parameters:
- `ADDR_W`, 18: memory address width; cart region depth is 2^ADDR_W bytes.
- `HDR_LEN`, 128: header bytes stripped when the signature matches.
- `FIFO_DEPTH`, 4: write-buffer entries, power of two, minimum 2.
- `BIOS_INDEX`, 8'd0: `ioctl_index` value that selects the BIOS region; any other value selects cart.

Ports:
- `clk_sys` in 1: sole clock.
- `reset` in 1: **asynchronous, active-high** reset.
- `ioctl_download` in 1: download active.
- `ioctl_index` in 8: target select.
- `ioctl_addr` in 25: byte address within the file.
- `ioctl_dout` in 8: byte data.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_wait` out 1: host must hold off `ioctl_wr` while this is high.
- `mem_we` out 1: a write request is valid.
- `mem_sel` out 1: target region, 0=BIOS, 1=cart.
- `mem_addr` out ADDR_W: write address.
- `mem_data` out 8: write data.
- `mem_ack` in 1: memory accepts the current request.
- `cart_is_7800` out 1: bytes 1..5 of the file equal "ATARI".
- `cart_flags` out 16: header bytes 53:54.
- `joy0_type` out 8: header byte 55.
- `joy1_type` out 8: header byte 56.
- `cart_region` out 8: header byte 57.
- `cart_save` out 8: header byte 58.
- `cart_size` out 32: payload byte count of the last cart download.
- `load_done` out 1: one-cycle pulse when a download has fully drained.
- `busy` out 1: high in LOAD or DRAIN.
- `err_overflow` out 1: sticky; set if a byte arrives while the FIFO is full.

## Operation
- Reset values: all outputs are 0. FSM state is IDLE.
- FSM states:
  - IDLE → LOAD on `ioctl_download` rising edge. At that edge, latch the region as (`ioctl_index`!=BIOS_INDEX). For a cart load, also clear all header registers, `cart_is_7800` and `err_overflow`.
  - LOAD → DRAIN on `ioctl_download` falling edge.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → IDLE after one cycle. `load_done`=1 only in DONE.
- Header capture (cart region only, on `ioctl_wr`): bytes at the addresses listed under Interface load their fields. `cart_flags` = {byte53, byte54}.
- `cart_is_7800` updates when byte 5 is written: it is set if bytes 1..5 equal "ATARI".
- Write filtering (cart region, `cart_is_7800`=1):
  - addr < HDR_LEN: no push.
  - Otherwise push with address addr−HDR_LEN.
  - Bytes 0..5 arrive before the signature is known and are pushed at their raw address. Payload later overwrites them.
- Write filtering (all other cases): push with address ioctl_addr[ADDR_W-1:0].
- Push entry = {sel, addr, data}, only in LOAD.
- `mem_we` = FIFO not empty. The head entry is presented on `mem_sel`/`mem_addr`/`mem_data` and held stable until `mem_ack`.
- Pop on `mem_we & mem_ack`.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Push while full: the byte is dropped and `err_overflow` is set. Nothing else changes.
- `ioctl_wait`:
  - Registered.
  - High when occupancy ≥ FIFO_DEPTH−1 after the current cycle's push/pop.
  - Forced high in DRAIN and DONE.
- Size: track the last written `ioctl_addr` during a cart LOAD. On the falling edge, `cart_size` = last_addr + 1 − (cart_is_7800 ? HDR_LEN : 0), 32-bit.
  - No writes during the load: `cart_size` = 0.
  - Computed value below 0: clamp to 0.
- BIOS loads never modify `cart_size` or any header field.
- `reset` mid-load: FIFO is flushed, FSM returns to IDLE, and all outputs return to 0 immediately.

## Timing
- `ioctl_wr` at cycle N → entry on the memory port with `mem_we`=1 at N+1 (FIFO previously empty).
- Throughput: one push and one pop per cycle.
- With `mem_ack` tied to 1, `ioctl_wait` stays 0 during LOAD.
- `cart_size` and `cart_is_7800` are valid from the cycle after the falling edge of `ioctl_download` and hold until the next cart load starts.
- `load_done` fires exactly one cycle after the last pop.

## Test plan
- BIOS load, index 0, 4096 bytes, `mem_ack`=1:
  - 4096 writes with `mem_sel`=0 and `mem_addr`=0..4095.
  - `cart_size` stays 0.
  - One `load_done` pulse.
- 7800 cart, header "ATARI" plus flags 0x1234 at bytes 53:54, region byte 57 = 1, 128+32768 bytes:
  - `cart_is_7800`=1, `cart_flags`=0x1234, `cart_region`=1.
  - `cart_size`=32768.
  - File byte 128 is written to `mem_addr` 0.
  - No writes to addresses 6..127.
- Raw 2600 image of 4096 bytes with byte1 ≠ 'A':
  - `cart_is_7800`=0, `cart_size`=4096.
  - Addresses pass through unchanged.
- Backpressure: `mem_ack` low for 10 cycles, FIFO_DEPTH=4:
  - `ioctl_wait` rises once 3 entries are held.
  - A host that honours `ioctl_wait` causes no `err_overflow`.
  - Data order is preserved after `mem_ack` returns.
- Overflow: host ignores `ioctl_wait` and pushes 6 bytes with `mem_ack`=0:
  - `err_overflow`=1.
  - Exactly 4 entries are drained once `mem_ack` returns.
- Reset asserted mid-load at byte 200:
  - All outputs are 0 immediately and `mem_we`=0.
  - A subsequent full load behaves as in the 7800 cart scenario.
